// File: rtl/booth_32.sv
`default_nettype none
// ============================================================================
// Module   : booth_32
// Purpose  : Sequential radix-2 Booth multiplier, 32x32 signed -> 64-bit
//            product, one iteration per clock over 32 iterations.
// Revision : 1.0 - initial release
// ============================================================================
module booth_32 (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] M,
    input  logic [31:0] Q,
    input  logic        start,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [32:0] r_a;
    logic [32:0] r_m;
    logic [31:0] r_qr;
    logic        r_q_m1;
    logic [5:0]  r_cnt;
    logic [63:0] r_result;

    logic [32:0] w_sum;

    assign result = r_result;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (r_cnt == 6'd1) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Booth recoding on {Qr[0], Q_-1}; the 33-bit width keeps A-M exact for M = -2^31
    always_comb begin
        w_sum = r_a;
        case ({r_qr[0], r_q_m1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_a      <= 33'd0;
            r_m      <= 33'd0;
            r_qr     <= 32'd0;
            r_q_m1   <= 1'b0;
            r_cnt    <= 6'd0;
            r_result <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a    <= 33'd0;
                        r_m    <= {M[31], M};
                        r_qr   <= Q;
                        r_q_m1 <= 1'b0;
                        r_cnt  <= 6'd32;
                    end
                end
                RUN: begin
                    // Arithmetic right shift of {A, Qr, Q_-1}
                    r_a    <= {w_sum[32], w_sum[32:1]};
                    r_qr   <= {w_sum[0], r_qr[31:1]};
                    r_q_m1 <= r_qr[0];
                    r_cnt  <= r_cnt - 6'd1;
                end
                DONE: begin
                    r_result <= {r_a[31:0], r_qr};
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_32
// Purpose  : Randomised scoreboard bench for booth_32 against an arithmetic
//            reference product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_32;

    logic        clk;
    logic        n_rst;
    logic [31:0] M;
    logic [31:0] Q;
    logic        start;
    logic [63:0] result;

    booth_32 dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .M      (M),
        .Q      (Q),
        .start  (start),
        .result (result)
    );

    typedef struct {
        int          due;
        logic [63:0] exp;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          cyc        = 0;
    int          n_vectors  = 0;
    int          n_miscomp  = 0;
    bit          checking   = 1'b0;
    logic [63:0] held       = 64'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_product(input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        a = longint'($signed(m));
        b = longint'($signed(q));
        return 64'(a * b);
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscomp++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: product expected exactly at its due edge, held value at every other edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (checking) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                held = sb[0].exp;
                sb.pop_front();
                compare("product", result, held);
            end else begin
                compare("hold", result, held);
            end
            if (sb.size() > 0 && sb[0].due < cyc) begin
                n_vectors++;
                n_miscomp++;
                $display("FAIL timeout cyc=%0d got=%h expected=%h", cyc, result, sb[0].exp);
                sb.pop_front();
            end
        end
    end

    task automatic push_op(input logic [31:0] m, input logic [31:0] q);
        sb_entry_t e;
        e.due = cyc + 1 + 33;
        e.exp = ref_product(m, q);
        sb.push_back(e);
    endtask

    // One start pulse; optionally a second, ignored pulse 5 edges after acceptance
    task automatic do_op(input logic [31:0] m, input logic [31:0] q, input bit repulse);
        @(negedge clk);
        M = m;
        Q = q;
        start = 1'b1;
        push_op(m, q);
        @(negedge clk);
        start = 1'b0;
        M = $urandom;
        Q = $urandom;
        for (int i = 1; i < 34; i++) begin
            @(negedge clk);
            M = $urandom;
            Q = $urandom;
            start = repulse && (i == 4);
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        M     = 32'd0;
        Q     = 32'd0;
        repeat (3) @(negedge clk);
        held     = 64'd0;
        checking = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;

        do_op(32'h0000_0008, 32'h0000_0014, 1'b0);
        do_op(32'hFFFF_FFF8, 32'h0000_0010, 1'b0);
        do_op(32'hFFFF_FFD5, 32'h0000_0003, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        do_op(32'h1234_5678, 32'hFEDC_BA98, 1'b1);

        // Abort an operation with reset at its 10th cycle
        @(negedge clk);
        M = 32'h0000_1111;
        Q = 32'h0000_2222;
        start = 1'b1;
        push_op(M, Q);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_rst = 1'b0;
        sb.delete();
        held = 64'd0;
        @(negedge clk);
        n_rst = 1'b1;
        do_op(32'hFFFF_FFF8, 32'h0000_0010, 1'b0);

        // start held high continuously: back-to-back operations
        @(negedge clk);
        M = 32'hDEAD_BEEF;
        Q = 32'h0BAD_F00D;
        start = 1'b1;
        push_op(M, Q);
        for (int i = 1; i < 34; i++) begin
            @(negedge clk);
            M = $urandom;
            Q = $urandom;
        end
        @(negedge clk);
        M = 32'h8000_0000;
        Q = 32'h7FFF_FFFF;
        push_op(M, Q);
        @(negedge clk);
        start = 1'b0;
        repeat (34) @(negedge clk);

        for (int n = 0; n < 16; n++) begin
            do_op(pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_vectors++;
            n_miscomp++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscomp);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
